// File: rtl/fsm_pkg.sv
// Shared definitions for the fsm_comb datapath: the debounce default, the state
// encoding, and a counter-width helper used by the input conditioning stage.
package fsm_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_SELECT  = 2'b01,
      ST_OPERATE = 2'b10,
      ST_DONE    = 2'b11
   } state_t;

   // Width needed to hold the values 0 .. n.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One input channel: 2-flop synchronizer, debounce counter and accepted level.
// Counter logic exists only when FSM_INPUT_COND_DEBOUNCE_EN is defined.
module debounce_chan
   import fsm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stb,
   output logic rise
);

   if (DEBOUNCE_CYCLES == 0) begin : g_bad_cycles
      $error("debounce_chan: DEBOUNCE_CYCLES must be at least 1");
   end

   logic s1;
   logic s2;
   logic stb_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

`ifdef FSM_INPUT_COND_DEBOUNCE_EN
   localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Any sample that agrees with the accepted level restarts the run.
   always_comb begin
      stb_d = stb;
      cnt_d = '0;
      if (s2 != stb) begin
         if (cnt_q == CNT_LAST) begin
            stb_d = s2;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   always_comb begin
      stb_d = s2;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb <= 1'b0;
      end else begin
         stb <= stb_d;
      end
   end

   // High when the accepted level will go 0->1 on the coming edge.
   assign rise = stb_d & ~stb;

endmodule

// File: rtl/fsm_input_cond.sv
// Input conditioning ahead of fsm_comb: synchronized, debounced op strobe and
// select level. Debounce counters are built only with FSM_INPUT_COND_DEBOUNCE_EN.
module fsm_input_cond
   import fsm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic op_raw,
   input  logic select_raw,
   output logic op,
   output logic select
);

   logic op_stb;
   logic op_rise;
   logic select_rise;

   debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_op_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (op_raw),
      .stb   (op_stb),
      .rise  (op_rise)
   );

   debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_select_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (select_raw),
      .stb   (select),
      .rise  (select_rise)
   );

   // The pulse lands on the same edge as the accepted op level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op <= 1'b0;
      end else begin
         op <= op_rise;
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, op_stb, select_rise};

endmodule

// File: tb/tb_fsm_input_cond.sv
// Directed self-checking bench for fsm_input_cond with DEBOUNCE_CYCLES = 4;
// expectations follow FSM_INPUT_COND_DEBOUNCE_EN as seen by this compile.
module tb_fsm_input_cond;

   localparam int unsigned DC = 4;
`ifdef FSM_INPUT_COND_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
   localparam int LAT = DC + 1;
`else
   localparam bit DEB = 1'b0;
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic op_raw;
   logic select_raw;
   logic op;
   logic select;

   int errors = 0;
   int checks = 0;

   fsm_input_cond #(
      .DEBOUNCE_CYCLES (DC)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op_raw     (op_raw),
      .select_raw (select_raw),
      .op         (op),
      .select     (select)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      op_raw     = 1'b1;
      select_raw = 1'b1;

      // Reset hold with both raw inputs high.
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("rst_hold_op[%0d]", i), op, 1'b0);
         chk($sformatf("rst_hold_sel[%0d]", i), select, 1'b0);
      end

      // Release with inputs still high: one fresh press and select acceptance.
      rst_n = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         tick();
         chk($sformatf("rel_op[%0d]", i), op, 1'(i == LAT));
         chk($sformatf("rel_sel[%0d]", i), select, 1'(i >= LAT));
      end

      // Both released: select falls after the latency, op never pulses.
      op_raw     = 1'b0;
      select_raw = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         tick();
         chk($sformatf("fall_op[%0d]", i), op, 1'b0);
         chk($sformatf("fall_sel[%0d]", i), select, 1'(i < LAT));
      end

      // Clean press held 20 cycles, then release.
      op_raw = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("press_op[%0d]", i), op, 1'(i == LAT));
      end
      op_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("release_op[%0d]", i), op, 1'b0);
      end

      // Bounce: high 3 samples, low 1, then high.
      for (int i = 0; i < 16; i++) begin
         op_raw = (i == 3) ? 1'b0 : 1'b1;
         tick();
         chk($sformatf("bounce_op[%0d]", i), op,
             DEB ? 1'(i == 9) : 1'(i == 2 || i == 6));
      end
      op_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("bounce_rel_op[%0d]", i), op, 1'b0);
      end

      // Glitch reject: select high for 3 samples only.
      for (int i = 0; i < 11; i++) begin
         select_raw = (i < 3) ? 1'b1 : 1'b0;
         tick();
         chk($sformatf("glitch3_sel[%0d]", i), select,
             DEB ? 1'b0 : 1'(i >= 2 && i <= 4));
      end

      // Select held high, then dropped.
      select_raw = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         tick();
         chk($sformatf("sel_hold[%0d]", i), select, 1'(i >= LAT));
      end
      select_raw = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         tick();
         chk($sformatf("sel_drop[%0d]", i), select, 1'(i < LAT));
      end

      // Simultaneous rise on both inputs.
      op_raw     = 1'b1;
      select_raw = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         tick();
         chk($sformatf("simul_op[%0d]", i), op, 1'(i == LAT));
         chk($sformatf("simul_sel[%0d]", i), select, 1'(i >= LAT));
      end
      op_raw     = 1'b0;
      select_raw = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         tick();
         chk($sformatf("simul_fall_op[%0d]", i), op, 1'b0);
         chk($sformatf("simul_fall_sel[%0d]", i), select, 1'(i < LAT));
      end

      // Reset two cycles into an op count; the count must start over.
      op_raw = 1'b1;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_op_now", op, 1'b0);
      chk("midrst_sel_now", select, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("midrst_op[%0d]", i), op, 1'b0);
      end
      rst_n = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         tick();
         chk($sformatf("post_rst_op[%0d]", i), op, 1'(i == LAT));
         chk($sformatf("post_rst_sel[%0d]", i), select, 1'b0);
      end
      op_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
      end
      chk("post_rst_settle_op", op, 1'b0);

      // Single-sample glitch on select.
      for (int i = 0; i < 8; i++) begin
         select_raw = (i == 0) ? 1'b1 : 1'b0;
         tick();
         chk($sformatf("glitch1_sel[%0d]", i), select,
             DEB ? 1'b0 : 1'(i == 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard bound on run time in case the sequence above stalls.
   initial begin
      #200000;
      $display("FAIL timeout: observed no completion, expected finish before 200000 ns");
      $fatal(1, "timeout");
   end

endmodule
